// File: rtl/axi_lite_read_arbiter.sv
// ============================================================================
// Module   : axi_lite_read_arbiter
// Brief    : Round-robin arbiter sharing one AXI-Lite read master port among
//            NUM_REQ requesters. Optional stall timeout under ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REG_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [NUM_REQ-1:0]             REQ_RRQST,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   REQ_RADDR,
    output logic [NUM_REQ-1:0]             REQ_GRANT,
    output logic [REG_WIDTH-1:0]           REQ_RDATA,
    output logic [NUM_REQ-1:0]             REQ_RVALID,
    output logic                           REQ_RERR,
    output logic                           M_RRQST,
    output logic [REG_WIDTH-1:0]           M_RADDR,
    input  logic                           M_ARACK,
    input  logic [REG_WIDTH-1:0]           M_RDATA,
    input  logic                           M_RDONE,
    output logic                           BUSY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("axi_lite_read_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_rvalid;
    logic [REG_WIDTH-1:0]   r_rdata;
    logic [REG_WIDTH-1:0]   r_maddr;
    logic                   r_mrrqst;

    logic                   w_any;
    logic [PTR_W-1:0]       w_win;
    logic [PTR_W-1:0]       w_cand;
    int                     w_idx;

    // First requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        w_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_cand = PTR_W'(w_idx);
            if (!w_any && REQ_RRQST[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rerr;
    logic             w_tmo;
    assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign REQ_RERR = r_rerr;
`else
    assign REQ_RERR = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= S_IDLE;
            r_ptr    <= PTR_W'(NUM_REQ - 1);
            r_grant  <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_maddr  <= '0;
            r_mrrqst <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_rerr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                        r_maddr  <= REQ_RADDR[w_win*REG_WIDTH +: REG_WIDTH];
                        r_ptr    <= w_win;
                        r_mrrqst <= 1'b1;
                        r_state  <= S_ADDR;
`ifdef ARB_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                S_ADDR: begin
                    if (M_ARACK) begin
                        r_mrrqst <= 1'b0;
                        r_state  <= S_DATA;
`ifdef ARB_TIMEOUT_EN
                        r_cnt    <= '0;
                    end else if (w_tmo) begin
                        r_mrrqst <= 1'b0;
                        r_rvalid <= r_grant;
                        r_rdata  <= '0;
                        r_rerr   <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
`endif
                    end
                end
                S_DATA: begin
                    if (M_RDONE) begin
                        r_rdata  <= M_RDATA;
                        r_rvalid <= r_grant;
                        r_state  <= S_RESP;
`ifdef ARB_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_rvalid <= r_grant;
                        r_rdata  <= '0;
                        r_rerr   <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    r_grant  <= '0;
                    r_rvalid <= '0;
                    r_rdata  <= '0;
                    r_state  <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
                    r_rerr   <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign REQ_GRANT  = r_grant;
    assign REQ_RVALID = r_rvalid;
    assign REQ_RDATA  = r_rdata;
    assign M_RRQST    = r_mrrqst;
    assign M_RADDR    = r_maddr;
    assign BUSY       = (r_state != S_IDLE);

endmodule

`default_nettype wire
